moving_avg_delay_filter: RTL and testbench
==========================================

Name: moving_avg_delay_filter

Overview:
Dual-channel (SIN/COS) moving-sum filter whose window length is set at run time by the DELAY/DELAY_UPDATED pair from the autoscale control. Outputs the full-width window sums downstream. Also drives the feedback side of that loop: top bits of each sum (TOP_SIN/TOP_COS) plus a periodic UPDATE request back to the autoscale control.

Parameters:
IN_BITS, 12, signed input sample width
DELAY_BITS, 4, DELAY width; window length N = DELAY+1, max 2^DELAY_BITS
TOP_DATA_BITS, 4, width of TOP_SIN/TOP_COS (MSBs of the sum)
UPDATE_PERIOD_BITS, 4, UPDATE fires every 2^UPDATE_PERIOD_BITS valid outputs

Ports:
CLK  in  1  clock; one clock domain
RESET  in  1  synchronous reset, active-high
CE  in  1  clock enable; one sample per CLK with CE=1
IN_SIN  in  IN_BITS  signed SIN sample
IN_COS  in  IN_BITS  signed COS sample
DELAY  in  DELAY_BITS  window length minus 1
DELAY_UPDATED  in  1  1 for one CE cycle when DELAY changes
OUT_SIN  out  IN_BITS+DELAY_BITS  signed window sum, SIN
OUT_COS  out  IN_BITS+DELAY_BITS  signed window sum, COS
OUT_VALID  out  1  1 when the window is full and OUT_* is a complete N-sample sum
TOP_SIN  out  TOP_DATA_BITS  OUT_SIN[MSB -: TOP_DATA_BITS]
TOP_COS  out  TOP_DATA_BITS  OUT_COS[MSB -: TOP_DATA_BITS]
UPDATE  out  1  1 for one CE cycle; requests an autoscale decision

Behaviour:
- Reset: ring buffers need not be cleared. Reset values: acc_sin, acc_cos, OUT_*, TOP_* = 0; OUT_VALID = 0; UPDATE = 0; wr_ptr = 0; fill_cnt = 0; state = FILL; period counter = 0.
- CE=0: no state changes and all outputs hold. UPDATE holds too, so a pulse lasts exactly one CE cycle.
- Ring buffer:
  - Depth 2^DELAY_BITS per channel, write address wr_ptr; wr_ptr increments by 1 per CE and wraps mod depth.
  - Oldest-sample address rd = (wr_ptr - N) mod depth. For N = depth, rd == wr_ptr.
  - Read must return the content before the same-cycle write (asynchronous or read-first RAM).
- Accumulator width IN_BITS+DELAY_BITS, two's complement, sign-extended operands; never overflows.
- States:
  - FILL, no restart: acc <= acc + in; fill_cnt++. When fill_cnt reaches N after this update, go to RUN and set OUT_VALID=1 in the same cycle.
  - RUN: acc <= acc + in - buf[rd]; OUT_VALID stays 1.
- Restart: CE & DELAY_UPDATED, in any state.
  - acc <= in (this sample is the first of the new window); fill_cnt <= 1; state <= FILL; OUT_VALID <= 0; period counter <= 0.
  - The new DELAY value applies from this cycle on.
  - If N==1, go straight to RUN with OUT_VALID=1.
- Outputs:
  - OUT_*, TOP_*, OUT_VALID are registered: one CE cycle of latency from sample to sum.
  - OUT_* also updates during FILL (partial sums), with OUT_VALID=0.
- UPDATE:
  - The period counter increments on each CE cycle with OUT_VALID=1 (post-update value).
  - UPDATE=1 on the CE cycle where the counter wraps to 0.
  - Never asserted in FILL or in the restart cycle.
- DELAY changing without DELAY_UPDATED: ignored until the next DELAY_UPDATED; the latched N is used throughout.
- RESET takes priority over CE and DELAY_UPDATED. RESET mid-window discards the partial sum.

Decomposition:
- Shared package: no typedefs. Width constants SUM_BITS = IN_BITS+DELAY_BITS and DEPTH = 2^DELAY_BITS go in localparams.
- One natural sub-module, moving_sum_channel: ring buffer, accumulator and output register for one channel. It is instantiated twice.
- The top level holds wr_ptr, fill_cnt, FILL/RUN state, the latched N and the UPDATE counter, all shared by both channels.

Test Plan:
- Reset: assert RESET 2 cycles with CE=1 and nonzero inputs -> OUT_*=0, TOP_*=0, OUT_VALID=0, UPDATE=0.
- Constant fill: DELAY=3 pulsed with DELAY_UPDATED, IN_SIN=100, IN_COS=-50 every CE -> OUT_VALID rises after the 4th sample with OUT_SIN=400, OUT_COS=-200, then stays constant.
- Full depth and wrap: DELAY=15, IN_SIN=2047, IN_COS=-2048 -> OUT_SIN=32752, TOP_SIN=4'b0111; OUT_COS=-32768, TOP_COS=4'b1000; values stable past 40 samples (pointer wrap).
- Restart mid-run: at steady state with DELAY=15, pulse DELAY_UPDATED with DELAY=1 and input 10 -> OUT_VALID=0 for one cycle, then OUT_SIN=20 with OUT_VALID=1; stale samples are not subtracted.
- CE gating: toggle CE in a random pattern -> results match the CE=1-every-cycle reference model sample for sample; UPDATE pulses exactly once per 16 valid outputs and is never high in FILL.
- Ramp input 0,1,2,... with DELAY=3 -> OUT_SIN = 4k-6 at sample index k≥3; compared against the model.

Source files
------------

// File: rtl/moving_avg_delay_filter_pkg.sv
// Shared width constants for the SIN/COS moving-sum filter.
package moving_avg_delay_filter_pkg;

  localparam int IN_BITS_DEF            = 12;
  localparam int DELAY_BITS_DEF         = 4;
  localparam int TOP_DATA_BITS_DEF      = 4;
  localparam int UPDATE_PERIOD_BITS_DEF = 4;

  // Full-width window sum and ring depth for the default configuration.
  localparam int SUM_BITS = IN_BITS_DEF + DELAY_BITS_DEF;
  localparam int DEPTH    = 2 ** DELAY_BITS_DEF;

endpackage

// File: rtl/moving_avg_delay_filter_channel.sv
// One channel of the moving sum: ring buffer, running accumulator and the
// registered sum/top-bits outputs. Control (pointers, mode) comes from the top.
module moving_sum_channel
  import moving_avg_delay_filter_pkg::*;
#(
  parameter int IN_BITS       = IN_BITS_DEF,
  parameter int DELAY_BITS    = DELAY_BITS_DEF,
  parameter int TOP_DATA_BITS = TOP_DATA_BITS_DEF
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  ce_i,
  input  logic                                  restart_i,
  input  logic                                  sub_i,
  input  logic        [DELAY_BITS-1:0]          wr_ptr_i,
  input  logic        [DELAY_BITS-1:0]          rd_ptr_i,
  input  logic signed [IN_BITS-1:0]             sample_i,
  output logic signed [IN_BITS+DELAY_BITS-1:0]  sum_o,
  output logic        [TOP_DATA_BITS-1:0]       top_o
);

  localparam int SUM_W = IN_BITS + DELAY_BITS;
  localparam int RING  = 2 ** DELAY_BITS;

  logic signed [IN_BITS-1:0] ring_q [RING];
  logic signed [SUM_W-1:0]   sum_q;
  logic signed [SUM_W-1:0]   sum_d;

  function automatic logic signed [SUM_W-1:0] sext(input logic signed [IN_BITS-1:0] x);
    return SUM_W'(x);
  endfunction

  // Next accumulator: reload on restart, grow while filling, slide once running.
  // The ring read is combinational, so it sees the value before this cycle's write.
  always_comb begin
    sum_d = sum_q;
    if (restart_i)
      sum_d = sext(sample_i);
    else if (sub_i)
      sum_d = sum_q + sext(sample_i) - sext(ring_q[rd_ptr_i]);
    else
      sum_d = sum_q + sext(sample_i);
  end

  // Sample history; contents are don't-care after reset, so no clear.
  always_ff @(posedge clk_i) begin
    if (ce_i)
      ring_q[wr_ptr_i] <= sample_i;
  end

  // Accumulator doubles as the registered output.
  always_ff @(posedge clk_i) begin
    if (rst_i)
      sum_q <= '0;
    else if (ce_i)
      sum_q <= sum_d;
  end

  assign sum_o = sum_q;
  assign top_o = sum_q[SUM_W-1 -: TOP_DATA_BITS];

endmodule

// File: rtl/moving_avg_delay_filter.sv
// Dual-channel run-time-length moving sum. Owns the shared write pointer,
// fill counter, FILL/RUN state, latched window length and UPDATE period counter.
module moving_avg_delay_filter
  import moving_avg_delay_filter_pkg::*;
#(
  parameter int IN_BITS            = IN_BITS_DEF,
  parameter int DELAY_BITS         = DELAY_BITS_DEF,
  parameter int TOP_DATA_BITS      = TOP_DATA_BITS_DEF,
  parameter int UPDATE_PERIOD_BITS = UPDATE_PERIOD_BITS_DEF
) (
  input  logic                                  CLK,
  input  logic                                  RESET,
  input  logic                                  CE,
  input  logic signed [IN_BITS-1:0]             IN_SIN,
  input  logic signed [IN_BITS-1:0]             IN_COS,
  input  logic        [DELAY_BITS-1:0]          DELAY,
  input  logic                                  DELAY_UPDATED,
  output logic signed [IN_BITS+DELAY_BITS-1:0]  OUT_SIN,
  output logic signed [IN_BITS+DELAY_BITS-1:0]  OUT_COS,
  output logic                                  OUT_VALID,
  output logic        [TOP_DATA_BITS-1:0]       TOP_SIN,
  output logic        [TOP_DATA_BITS-1:0]       TOP_COS,
  output logic                                  UPDATE
);

  typedef enum logic {FILL, RUN} state_t;

  logic [DELAY_BITS-1:0]         wr_ptr_q, wr_ptr_d;
  logic [DELAY_BITS:0]           fill_cnt_q, fill_cnt_d;
  logic [DELAY_BITS:0]           n_q, n_d, n_eff;
  logic [UPDATE_PERIOD_BITS-1:0] per_q, per_d;
  state_t                        state_q, state_d;
  logic                          valid_q, valid_d;
  logic                          upd_q, upd_d;
  logic                          restart;
  logic                          sub;
  logic [DELAY_BITS-1:0]         rd_ptr;

  // A restart takes the new window length in the same cycle; otherwise use the latched one.
  // Oldest address wraps naturally: N == depth maps to an offset of zero.
  always_comb begin
    restart = CE & DELAY_UPDATED;
    n_eff   = restart ? ({1'b0, DELAY} + {{DELAY_BITS{1'b0}}, 1'b1}) : n_q;
    rd_ptr  = wr_ptr_q - n_eff[DELAY_BITS-1:0];
    sub     = (state_q == RUN) && !restart;
  end

  // Control next-state: restart overrides FILL/RUN; UPDATE counts valid outputs.
  always_comb begin
    wr_ptr_d   = wr_ptr_q + 1'b1;
    fill_cnt_d = fill_cnt_q;
    n_d        = n_q;
    state_d    = state_q;
    valid_d    = valid_q;
    per_d      = per_q;
    upd_d      = 1'b0;
    if (restart) begin
      fill_cnt_d = {{DELAY_BITS{1'b0}}, 1'b1};
      n_d        = n_eff;
      per_d      = '0;
      if (n_eff == {{DELAY_BITS{1'b0}}, 1'b1}) begin
        state_d = RUN;
        valid_d = 1'b1;
      end else begin
        state_d = FILL;
        valid_d = 1'b0;
      end
    end else begin
      if (state_q == FILL) begin
        fill_cnt_d = fill_cnt_q + 1'b1;
        if (fill_cnt_d == n_q) begin
          state_d = RUN;
          valid_d = 1'b1;
        end
      end else begin
        valid_d = 1'b1;
      end
      if (valid_d)
        per_d = per_q + 1'b1;
      upd_d = valid_d && (per_d == '0);
    end
  end

  // Control registers advance only on CE; reset wins over everything.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_q   <= '0;
      fill_cnt_q <= '0;
      n_q        <= (DELAY_BITS+1)'(2 ** DELAY_BITS);
      state_q    <= FILL;
      valid_q    <= 1'b0;
      per_q      <= '0;
      upd_q      <= 1'b0;
    end else if (CE) begin
      wr_ptr_q   <= wr_ptr_d;
      fill_cnt_q <= fill_cnt_d;
      n_q        <= n_d;
      state_q    <= state_d;
      valid_q    <= valid_d;
      per_q      <= per_d;
      upd_q      <= upd_d;
    end
  end

  assign OUT_VALID = valid_q;
  assign UPDATE    = upd_q;

  moving_sum_channel #(
    .IN_BITS(IN_BITS), .DELAY_BITS(DELAY_BITS), .TOP_DATA_BITS(TOP_DATA_BITS)
  ) u_sin (
    .clk_i(CLK), .rst_i(RESET), .ce_i(CE), .restart_i(restart), .sub_i(sub),
    .wr_ptr_i(wr_ptr_q), .rd_ptr_i(rd_ptr), .sample_i(IN_SIN),
    .sum_o(OUT_SIN), .top_o(TOP_SIN)
  );

  moving_sum_channel #(
    .IN_BITS(IN_BITS), .DELAY_BITS(DELAY_BITS), .TOP_DATA_BITS(TOP_DATA_BITS)
  ) u_cos (
    .clk_i(CLK), .rst_i(RESET), .ce_i(CE), .restart_i(restart), .sub_i(sub),
    .wr_ptr_i(wr_ptr_q), .rd_ptr_i(rd_ptr), .sample_i(IN_COS),
    .sum_o(OUT_COS), .top_o(TOP_COS)
  );

endmodule

// File: tb/tb_moving_avg_delay_filter.sv
// Directed bench for moving_avg_delay_filter with a window-sum reference model.
module tb_moving_avg_delay_filter;

  logic               CLK = 1'b0;
  logic               RESET, CE, DELAY_UPDATED;
  logic signed [11:0] IN_SIN, IN_COS;
  logic        [3:0]  DELAY;
  logic signed [15:0] OUT_SIN, OUT_COS;
  logic               OUT_VALID, UPDATE;
  logic        [3:0]  TOP_SIN, TOP_COS;

  int nvec = 0;
  int nerr = 0;

  // Reference model state
  int     hs[$];
  int     hc[$];
  int     m_n   = 16;
  int     m_cnt = 0;
  longint m_sin = 0;
  longint m_cos = 0;
  bit     m_vld = 0;
  bit     m_upd = 0;

  always #5 CLK = ~CLK;

  moving_avg_delay_filter dut (
    .CLK(CLK), .RESET(RESET), .CE(CE), .IN_SIN(IN_SIN), .IN_COS(IN_COS),
    .DELAY(DELAY), .DELAY_UPDATED(DELAY_UPDATED),
    .OUT_SIN(OUT_SIN), .OUT_COS(OUT_COS), .OUT_VALID(OUT_VALID),
    .TOP_SIN(TOP_SIN), .TOP_COS(TOP_COS), .UPDATE(UPDATE)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    if (RESET) begin
      hs.delete(); hc.delete();
      m_n = 16; m_cnt = 0; m_sin = 0; m_cos = 0; m_vld = 0; m_upd = 0;
    end else if (CE) begin
      if (DELAY_UPDATED) begin
        hs.delete(); hc.delete();
        m_n = int'(DELAY) + 1;
      end
      hs.push_back(int'(IN_SIN));
      hc.push_back(int'(IN_COS));
      if (hs.size() > 16) begin
        void'(hs.pop_front());
        void'(hc.pop_front());
      end
      m_sin = 0; m_cos = 0;
      for (int i = 0; i < m_n && i < hs.size(); i++) begin
        m_sin += hs[hs.size()-1-i];
        m_cos += hc[hc.size()-1-i];
      end
      m_vld = (hs.size() >= m_n);
      if (DELAY_UPDATED) begin
        m_cnt = 0; m_upd = 0;
      end else begin
        if (m_vld) m_cnt = (m_cnt + 1) % 16;
        m_upd = m_vld && (m_cnt == 0);
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
  endtask

  task automatic drive(input bit ce, input bit du, input int d, input int s, input int c);
    CE = ce; DELAY_UPDATED = du; DELAY = d[3:0];
    IN_SIN = s[11:0]; IN_COS = c[11:0];
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, "_sin"}, longint'(OUT_SIN), m_sin);
    chk({tag, "_cos"}, longint'(OUT_COS), m_cos);
    chk({tag, "_vld"}, longint'(OUT_VALID), longint'(m_vld));
    chk({tag, "_upd"}, longint'(UPDATE), longint'(m_upd));
  endtask

  initial begin
    int upd_seen;
    // Reset with live inputs
    RESET = 1'b1;
    drive(1, 1, 5, 123, -77);
    tick(); tick();
    chk("rst_out_sin", longint'(OUT_SIN), 0);
    chk("rst_out_cos", longint'(OUT_COS), 0);
    chk("rst_top_sin", longint'(TOP_SIN), 0);
    chk("rst_top_cos", longint'(TOP_COS), 0);
    chk("rst_vld", longint'(OUT_VALID), 0);
    chk("rst_upd", longint'(UPDATE), 0);
    RESET = 1'b0;

    // Constant fill, N = 4
    for (int k = 0; k < 6; k++) begin
      drive(1, k == 0, 3, 100, -50);
      tick();
      cmp_model("fill");
      if (k == 2) begin
        chk("fill3_sin", longint'(OUT_SIN), 300);
        chk("fill3_vld", longint'(OUT_VALID), 0);
      end
      if (k == 3 || k == 5) begin
        chk("fill4_sin", longint'(OUT_SIN), 400);
        chk("fill4_cos", longint'(OUT_COS), -200);
        chk("fill4_vld", longint'(OUT_VALID), 1);
      end
    end

    // CE low: everything holds
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 9, 999, -999);
      tick();
    end
    chk("hold_sin", longint'(OUT_SIN), 400);
    chk("hold_cos", longint'(OUT_COS), -200);
    chk("hold_vld", longint'(OUT_VALID), 1);

    // Full depth, extremes, pointer wrap
    upd_seen = 0;
    for (int k = 0; k < 40; k++) begin
      drive(1, k == 0, 15, 2047, -2048);
      tick();
      cmp_model("full");
      if (UPDATE) upd_seen++;
      if (k == 14) chk("full15_vld", longint'(OUT_VALID), 0);
      if (k == 15 || k == 39) begin
        chk("full_sin", longint'(OUT_SIN), 32752);
        chk("full_cos", longint'(OUT_COS), -32768);
        chk("full_top_sin", longint'(TOP_SIN), 7);
        chk("full_top_cos", longint'(TOP_COS), 8);
        chk("full_vld", longint'(OUT_VALID), 1);
      end
    end
    chk("full_upd_count", upd_seen, 1);

    // Restart mid-run to N = 2
    drive(1, 1, 1, 10, 10);
    tick();
    chk("rs_vld0", longint'(OUT_VALID), 0);
    chk("rs_sin0", longint'(OUT_SIN), 10);
    chk("rs_upd0", longint'(UPDATE), 0);
    drive(1, 0, 1, 10, 10);
    tick();
    chk("rs_sin1", longint'(OUT_SIN), 20);
    chk("rs_vld1", longint'(OUT_VALID), 1);
    drive(1, 0, 1, 10, 10);
    tick();
    chk("rs_sin2", longint'(OUT_SIN), 20);
    cmp_model("rs");

    // N = 1: valid immediately on restart
    drive(1, 1, 0, 5, -5);
    tick();
    chk("n1_vld", longint'(OUT_VALID), 1);
    chk("n1_sin", longint'(OUT_SIN), 5);
    chk("n1_upd", longint'(UPDATE), 0);
    drive(1, 0, 0, -7, 7);
    tick();
    chk("n1_sin2", longint'(OUT_SIN), -7);
    chk("n1_cos2", longint'(OUT_COS), 7);

    // Ramp, N = 4; DELAY changes without DELAY_UPDATED are ignored
    for (int k = 0; k < 20; k++) begin
      drive(1, k == 0, (k >= 10) ? 0 : 3, k, -k);
      tick();
      cmp_model("ramp");
      if (k >= 3) begin
        chk("ramp_sin", longint'(OUT_SIN), 4 * k - 6);
        chk("ramp_cos", longint'(OUT_COS), 6 - 4 * k);
        chk("ramp_vld", longint'(OUT_VALID), 1);
      end else begin
        chk("ramp_vld", longint'(OUT_VALID), 0);
      end
    end

    // Random CE gating with random samples, N = 8
    drive(1, 1, 7, 0, 0);
    tick();
    cmp_model("rnd0");
    for (int k = 0; k < 200; k++) begin
      drive($urandom_range(0, 2) != 0, 0, 7,
            int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048);
      tick();
      cmp_model("rnd");
      chk("rnd_upd_fill", longint'(UPDATE && !OUT_VALID), 0);
    end

    // Reset mid-window discards the partial sum
    drive(1, 1, 7, 300, -300);
    tick();
    drive(1, 0, 7, 300, -300);
    tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("mrst_sin", longint'(OUT_SIN), 0);
    chk("mrst_vld", longint'(OUT_VALID), 0);
    drive(1, 1, 1, 40, -40);
    tick();
    drive(1, 0, 1, 2, -2);
    tick();
    chk("mrst_sin2", longint'(OUT_SIN), 42);
    cmp_model("mrst");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
